// File: rtl/timer_pkg.sv
// Shared encodings for the timer_dev memory-mapped countdown timer:
// FSM states, register offsets, MODE values and CTRL bit positions.
package timer_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_LOAD,
    ST_CNT,
    ST_INT
  } state_t;

  localparam logic [1:0] REG_CTRL   = 2'd0;
  localparam logic [1:0] REG_PRESET = 2'd1;
  localparam logic [1:0] REG_COUNT  = 2'd2;

  localparam logic [1:0] MODE_ONESHOT = 2'd0;
  localparam logic [1:0] MODE_RELOAD  = 2'd1;

  localparam int CTRL_EN   = 0;
  localparam int CTRL_MODE = 1;
  localparam int CTRL_IM   = 3;

  // Encodings 2 and 3 are reserved and behave as RELOAD.
  function automatic logic modeReloads(input logic [1:0] mode);
    return (mode == MODE_RELOAD) || mode[1];
  endfunction

endpackage

// File: rtl/timer_if.sv
// Data-side bus between the M stage and the timer: address, byte enables,
// store data in; hit, combinational read data and interrupt out.
interface timer_if;
  logic [31:0] addr;
  logic [3:0]  byteen;
  logic [31:0] wdata;
  logic        hit;
  logic [31:0] rdata;
  logic        irq;

  modport master (output addr, output byteen, output wdata,
                  input hit, input rdata, input irq);
  modport slave  (input addr, input byteen, input wdata,
                  output hit, output rdata, output irq);
endinterface

// File: rtl/timer_prescaler.sv
// Tick generator for timer_dev: o_tick is high one cycle in PRESCALE.
// Only instantiated when TIMER_PRESCALE_EN is defined.
module timer_prescaler #(
  parameter int PRESCALE = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic i_clear,
  output logic o_tick
);

  localparam int W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [W-1:0] LAST = W'(PRESCALE - 1);

  logic [W-1:0] r_cnt;

  assign o_tick = (r_cnt == LAST);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_cnt <= '0;
    end else if (i_clear || o_tick) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + W'(1);
    end
  end

endmodule

// File: rtl/timer_dev.sv
// Memory-mapped countdown timer with ONESHOT/RELOAD modes and level irq.
// Define TIMER_PRESCALE_EN to decrement only once every PRESCALE clocks.
module timer_dev
  import timer_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = 32'h0000_7F00,
  parameter int          CNT_W     = 32,
  parameter int          PRESCALE  = 4
) (
  input  logic    clk,
  input  logic    reset,
  timer_if.slave  bus
);

  state_t r_state, w_stateNext;

  logic             r_en;
  logic [1:0]       r_mode;
  logic             r_im;
  logic             r_irqFlag;
  logic [CNT_W-1:0] r_preset;
  logic [CNT_W-1:0] r_count;

  logic        w_hit;
  logic        w_wr;
  logic        w_wrCtrl;
  logic        w_wrPreset;
  logic        w_load;
  logic        w_dec;
  logic        w_setFlag;
  logic        w_clrEn;
  logic        w_tick;
  logic [31:0] w_rdata;
  logic [31:0] w_presetMerged;
  logic        w_unused;

  assign w_hit      = (bus.addr[31:4] == BASE_ADDR[31:4]) && (bus.addr[3:2] != 2'd3);
  assign w_wr       = w_hit && (bus.byteen != 4'h0);
  assign w_wrCtrl   = w_wr && (bus.addr[3:2] == REG_CTRL);
  assign w_wrPreset = w_wr && (bus.addr[3:2] == REG_PRESET);
  assign w_unused   = ^{bus.addr[1:0], (PRESCALE > 0)};

`ifdef TIMER_PRESCALE_EN
  timer_prescaler #(
    .PRESCALE (PRESCALE)
  ) u_prescaler (
    .clk     (clk),
    .reset   (reset),
    .i_clear ((r_state == ST_LOAD) || !r_en),
    .o_tick  (w_tick)
  );
`else
  assign w_tick = 1'b1;
`endif

  always_comb begin
    w_rdata = '0;
    if (w_hit) begin
      case (bus.addr[3:2])
        REG_CTRL: begin
          w_rdata[CTRL_EN]          = r_en;
          w_rdata[CTRL_MODE +: 2]   = r_mode;
          w_rdata[CTRL_IM]          = r_im;
        end
        REG_PRESET: w_rdata[CNT_W-1:0] = r_preset;
        REG_COUNT:  w_rdata[CNT_W-1:0] = r_count;
        default:    w_rdata = '0;
      endcase
    end
  end

  assign bus.hit   = w_hit;
  assign bus.rdata = w_rdata;
  assign bus.irq   = r_im & (r_irqFlag | ((r_state == ST_INT) & modeReloads(r_mode)));

  always_comb begin
    w_presetMerged = 32'(r_preset);
    for (int i = 0; i < 4; i++) begin
      if (bus.byteen[i]) begin
        w_presetMerged[8*i +: 8] = bus.wdata[8*i +: 8];
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_stateNext;
    end
  end

  always_comb begin
    w_stateNext = r_state;
    w_load      = 1'b0;
    w_dec       = 1'b0;
    w_setFlag   = 1'b0;
    w_clrEn     = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (r_en) w_stateNext = ST_LOAD;
      end
      ST_LOAD: begin
        w_load      = 1'b1;
        w_stateNext = ST_CNT;
      end
      ST_CNT: begin
        if (!r_en) begin
          w_stateNext = ST_IDLE;
        end else if (w_tick) begin
          if (r_count == '0) begin
            w_stateNext = ST_INT;
            w_setFlag   = (r_mode == MODE_ONESHOT);
          end else begin
            w_dec = 1'b1;
          end
        end
      end
      ST_INT: begin
        if (modeReloads(r_mode)) begin
          w_stateNext = ST_LOAD;
        end else begin
          w_clrEn     = 1'b1;
          w_stateNext = ST_IDLE;
        end
      end
      default: w_stateNext = ST_IDLE;
    endcase
  end

  // A CPU write to CTRL takes priority over the end-of-oneshot EN clear.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_en      <= 1'b0;
      r_mode    <= MODE_ONESHOT;
      r_im      <= 1'b0;
      r_irqFlag <= 1'b0;
      r_preset  <= '0;
      r_count   <= '0;
    end else begin
      if (w_wrCtrl && bus.byteen[0]) begin
        r_en   <= bus.wdata[CTRL_EN];
        r_mode <= bus.wdata[CTRL_MODE +: 2];
        r_im   <= bus.wdata[CTRL_IM];
      end else if (w_clrEn) begin
        r_en <= 1'b0;
      end
      if (w_wrCtrl) begin
        r_irqFlag <= 1'b0;
      end else if (w_setFlag) begin
        r_irqFlag <= 1'b1;
      end
      if (w_wrPreset) begin
        r_preset <= w_presetMerged[CNT_W-1:0];
      end
      if (w_load) begin
        r_count <= r_preset;
      end else if (w_dec) begin
        r_count <= r_count - CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_timer_dev.sv
// Self-checking bench for timer_dev: directed vectors with literal
// expectations plus a per-cycle compare against a timeline-based model.
module tb_timer_dev;

  localparam logic [31:0] BASE     = 32'h0000_7F00;
  localparam logic [31:0] A_CTRL   = BASE;
  localparam logic [31:0] A_PRESET = BASE + 32'd4;
  localparam logic [31:0] A_COUNT  = BASE + 32'd8;

  logic clk   = 1'b0;
  logic reset = 1'b0;
  int   nVectors = 0;
  int   nMiss    = 0;

  timer_if bus ();

  timer_dev #(
    .BASE_ADDR (BASE),
    .CNT_W     (32),
    .PRESCALE  (4)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Model: the count is derived from the edge index at which PRESET was
  // loaded, using the timeline COUNT = P-k after k edges, INT at k = P+1.
  logic        mEn, mIm, mFlag, mRunning;
  logic [1:0]  mMode;
  logic [31:0] mPreset, mCount, mP;
  longint      mCyc, mBase;

  function automatic logic modelHit(input logic [31:0] a);
    return (a[31:4] == BASE[31:4]) && (a[3:2] != 2'd3);
  endfunction

  function automatic logic [31:0] modelRdata(input logic [31:0] a);
    if (!modelHit(a)) return 32'h0;
    case (a[3:2])
      2'd0:    return {28'h0, mIm, mMode, mEn};
      2'd1:    return mPreset;
      2'd2:    return mCount;
      default: return 32'h0;
    endcase
  endfunction

  function automatic logic modelIrq();
    logic inInt;
    inInt = mRunning && (mCyc - mBase == longint'(mP) + 1);
    return mIm & (mFlag | (inInt && (mMode != 2'd0)));
  endfunction

  task automatic modelReset();
    mEn = 0; mIm = 0; mFlag = 0; mRunning = 0; mMode = 2'd0;
    mPreset = 0; mCount = 0; mP = 0; mBase = 0;
  endtask

  task automatic modelStep();
    logic   wr;
    longint kp;
    mCyc++;
    wr = modelHit(bus.addr) && (bus.byteen != 4'h0);
    if (!mRunning) begin
      if (mEn) begin
        mRunning = 1'b1;
        mBase    = mCyc + 1;
      end
    end else if (mCyc == mBase) begin
      mCount = mPreset;
      mP     = mPreset;
    end else begin
      kp = mCyc - 1 - mBase;
      if (kp <= longint'(mP)) begin
        if (!mEn) mRunning = 1'b0;
        else if (kp == longint'(mP)) begin
          if (mMode == 2'd0) mFlag = 1'b1;
        end else mCount = 32'(longint'(mP) - kp - 1);
      end else if (mMode != 2'd0) begin
        mBase = mCyc + 1;
      end else begin
        mEn      = 1'b0;
        mRunning = 1'b0;
      end
    end
    if (wr && bus.addr[3:2] == 2'd0) begin
      if (bus.byteen[0]) begin
        mEn   = bus.wdata[0];
        mMode = bus.wdata[2:1];
        mIm   = bus.wdata[3];
      end
      mFlag = 1'b0;
    end
    if (wr && bus.addr[3:2] == 2'd1) begin
      for (int i = 0; i < 4; i++)
        if (bus.byteen[i]) mPreset[8*i +: 8] = bus.wdata[8*i +: 8];
    end
  endtask

  initial begin
    mCyc = 0;
    modelReset();
    forever begin
      @(posedge clk or negedge reset);
      if (!reset) modelReset();
      else modelStep();
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    nVectors++;
    if (actual !== expected) begin
      nMiss++;
      $display("[TB] FAIL %s: got %h, expected %h at %0t", name, actual, expected, $time);
    end
  endtask

  initial begin
    forever begin
      @(negedge clk);
      checkOutput("model hit",   {31'b0, bus.hit}, {31'b0, modelHit(bus.addr)});
      checkOutput("model rdata", bus.rdata, modelRdata(bus.addr));
      checkOutput("model irq",   {31'b0, bus.irq}, {31'b0, modelIrq()});
    end
  end

  task automatic applyStimulus(input logic [31:0] a, input logic [3:0] be,
                               input logic [31:0] d);
    bus.addr   = a;
    bus.byteen = be;
    bus.wdata  = d;
  endtask

  task automatic stepCycle(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic writeReg(input logic [31:0] a, input logic [3:0] be,
                          input logic [31:0] d);
    applyStimulus(a, be, d);
    stepCycle();
    applyStimulus(a, 4'h0, 32'h0);
  endtask

  task automatic readCheck(input string name, input logic [31:0] a,
                           input logic [31:0] expected);
    applyStimulus(a, 4'h0, 32'h0);
    #1;
    checkOutput(name, bus.rdata, expected);
  endtask

  task automatic irqCheck(input string name, input logic expected);
    checkOutput(name, {31'b0, bus.irq}, {31'b0, expected});
  endtask

  initial begin
    applyStimulus(32'h0, 4'h0, 32'h0);

    // Writes while reset is held must have no effect.
    applyStimulus(A_PRESET, 4'hF, 32'hFFFF_FFFF);
    stepCycle(2);
    readCheck("preset in reset", A_PRESET, 32'h0);
    applyStimulus(A_CTRL, 4'hF, 32'h0000_000F);
    stepCycle();
    readCheck("ctrl in reset", A_CTRL, 32'h0);
    irqCheck("irq in reset", 1'b0);
    reset = 1'b1;
    stepCycle();
    readCheck("ctrl after reset", A_CTRL, 32'h0);
    readCheck("preset after reset", A_PRESET, 32'h0);
    readCheck("count after reset", A_COUNT, 32'h0);
    stepCycle();

    writeReg(A_PRESET, 4'b0101, 32'hAABB_CCDD);
    readCheck("preset byteen", A_PRESET, 32'h00BB_00DD);
    writeReg(A_COUNT, 4'hF, 32'd5);
    readCheck("count read-only", A_COUNT, 32'h0);

    applyStimulus(BASE + 32'd12, 4'hF, 32'hFFFF_FFFF);
    #1;
    checkOutput("hit offset 12", {31'b0, bus.hit}, 32'h0);
    checkOutput("rdata offset 12", bus.rdata, 32'h0);
    stepCycle();
    applyStimulus(32'h0000_7F14, 4'hF, 32'hFFFF_FFFF);
    #1;
    checkOutput("hit outside", {31'b0, bus.hit}, 32'h0);
    stepCycle();
    applyStimulus(32'h8000_7F04, 4'hF, 32'hFFFF_FFFF);
    #1;
    checkOutput("rdata outside", bus.rdata, 32'h0);
    stepCycle();
    readCheck("preset after misses", A_PRESET, 32'h00BB_00DD);
    readCheck("ctrl after misses", A_CTRL, 32'h0);
    readCheck("addr low bits ignored", 32'h0000_7F07, 32'h00BB_00DD);
    stepCycle();

    // ONESHOT, PRESET = 3, CTRL written at edge 0.
    writeReg(A_PRESET, 4'hF, 32'd3);
    writeReg(A_CTRL, 4'hF, 32'h9);
    stepCycle();
    for (int k = 0; k < 4; k++) begin
      stepCycle();
      readCheck("oneshot count", A_COUNT, 32'(3 - k));
    end
    stepCycle();
    irqCheck("oneshot irq edge6", 1'b1);
    stepCycle();
    readCheck("oneshot en cleared", A_CTRL, 32'h8);
    irqCheck("oneshot irq edge7", 1'b1);
    stepCycle(3);
    irqCheck("oneshot irq held", 1'b1);
    writeReg(A_CTRL, 4'hF, 32'h0);
    irqCheck("oneshot irq cleared", 1'b0);
    stepCycle(2);

    // PRESET = 0: INT after edge 3; CTRL write at edge 4 beats the EN clear.
    writeReg(A_PRESET, 4'hF, 32'd0);
    writeReg(A_CTRL, 4'hF, 32'h9);
    stepCycle(3);
    irqCheck("preset0 irq", 1'b1);
    writeReg(A_CTRL, 4'hF, 32'h9);
    readCheck("cpu write wins", A_CTRL, 32'h9);
    irqCheck("cpu write clears flag", 1'b0);
    writeReg(A_CTRL, 4'hF, 32'h0);
    stepCycle(3);

    // RELOAD, PRESET = 2: first pulse after edge 5, period 5.
    writeReg(A_PRESET, 4'hF, 32'd2);
    writeReg(A_CTRL, 4'hF, 32'hB);
    for (int e = 1; e <= 16; e++) begin
      stepCycle();
      irqCheck("reload pulse", (e >= 5) && ((e - 5) % 5 == 0));
    end
    writeReg(A_CTRL, 4'hF, 32'h3);
    for (int e = 0; e < 12; e++) begin
      stepCycle();
      irqCheck("reload masked", 1'b0);
    end
    writeReg(A_CTRL, 4'hF, 32'h0);
    stepCycle(6);

    // EN cleared while COUNT goes 8 -> 7, then restart with PRESET = 9.
    writeReg(A_PRESET, 4'hF, 32'd10);
    writeReg(A_CTRL, 4'hF, 32'h1);
    stepCycle(4);
    writeReg(A_CTRL, 4'hF, 32'h0);
    readCheck("count at clear", A_COUNT, 32'd7);
    for (int k = 0; k < 4; k++) begin
      stepCycle();
      readCheck("count holds", A_COUNT, 32'd7);
    end
    writeReg(A_PRESET, 4'hF, 32'd9);
    writeReg(A_CTRL, 4'hF, 32'h1);
    stepCycle();
    readCheck("restart t+1", A_COUNT, 32'd7);
    stepCycle();
    readCheck("restart reload", A_COUNT, 32'd9);
    writeReg(A_PRESET, 4'hF, 32'd50);
    readCheck("preset write mid count", A_COUNT, 32'd8);
    stepCycle();
    readCheck("count continues", A_COUNT, 32'd7);
    writeReg(A_CTRL, 4'hF, 32'h0);
    stepCycle(3);
    writeReg(A_CTRL, 4'hF, 32'h1);
    stepCycle(2);
    readCheck("new preset on next load", A_COUNT, 32'd50);
    writeReg(A_CTRL, 4'hF, 32'h0);
    stepCycle(3);

    // Reset during a RELOAD pulse drops irq without a clock edge.
    writeReg(A_PRESET, 4'hF, 32'd1);
    writeReg(A_CTRL, 4'hF, 32'hB);
    stepCycle(4);
    applyStimulus(A_PRESET, 4'h0, 32'h0);
    irqCheck("irq before reset", 1'b1);
    #1;
    reset = 1'b0;
    #1;
    irqCheck("irq async reset", 1'b0);
    checkOutput("rdata async reset", bus.rdata, 32'h0);
    readCheck("count async reset", A_COUNT, 32'h0);
    stepCycle(2);
    reset = 1'b1;
    stepCycle();
    readCheck("ctrl after mid reset", A_CTRL, 32'h0);
    stepCycle(2);

    $display("== %0d vectors applied, %0d miscompares ==", nVectors, nMiss);
    $finish;
  end

endmodule
